// File: rtl/act_stream_driver.sv
// Activation stream driver: forwards a frame to the accelerator with 1-cycle latency, appends FLUSH_CYCLES zero words,
// and serialises each wide result LSB-slice first; m_ready never stalls the accelerator, dropped results set overflow.
module act_stream_driver #(
    parameter int IN_W         = 24,
    parameter int OUT_W        = 2048,
    parameter int SER_W        = 64,
    parameter int FLUSH_CYCLES = 6272
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             dut_valid,
    output logic [IN_W-1:0]  dut_act,
    input  logic             dut_ready,
    input  logic [OUT_W-1:0] dut_out,
    output logic             m_valid,
    output logic [SER_W-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow
);

    localparam int BEATS  = OUT_W / SER_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(FLUSH_CYCLES + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  FLUSH_END = CNT_W'(FLUSH_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d, flush_cnt_inc;
    logic             dut_valid_q, dut_valid_d;
    logic [IN_W-1:0]  dut_act_q, dut_act_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;
    logic [OUT_W-1:0] shreg_q, shreg_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic             ser_vld_q, ser_vld_d;

    logic accept;
    logic frame_start;
    logic m_hs;
    logic last_hs;
    logic load;
    logic drop;

    assign s_ready       = (state_q == ST_IDLE) || (state_q == ST_STREAM);
    assign accept        = s_valid && s_ready;
    assign flush_cnt_inc = flush_cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        dut_valid_d  = 1'b0;
        dut_act_d    = dut_act_q;
        frame_done_d = 1'b0;
        frame_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dut_valid_d = 1'b1;
                    dut_act_d   = s_data;
                    frame_start = 1'b1;
                    flush_cnt_d = '0;
                    state_d     = s_last ? ST_FLUSH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    dut_valid_d = 1'b1;
                    dut_act_d   = s_data;
                    if (s_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                dut_valid_d = 1'b1;
                dut_act_d   = '0;
                flush_cnt_d = flush_cnt_inc;
                if (flush_cnt_inc == FLUSH_END) begin
                    flush_cnt_d = '0;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                dut_act_d = '0;
                if (!ser_vld_q) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new result may reuse the shift register in the very cycle its last beat leaves.
    assign m_hs    = ser_vld_q && m_ready;
    assign last_hs = m_hs && (beat_q == LAST_BEAT);
    assign load    = dut_ready && (!ser_vld_q || last_hs);
    assign drop    = dut_ready && !load;

    always_comb begin
        shreg_d   = shreg_q;
        beat_d    = beat_q;
        ser_vld_d = ser_vld_q;
        if (load) begin
            shreg_d   = dut_out;
            beat_d    = '0;
            ser_vld_d = 1'b1;
        end else if (m_hs) begin
            shreg_d = shreg_q >> SER_W;
            if (beat_q == LAST_BEAT) begin
                beat_d    = '0;
                ser_vld_d = 1'b0;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    // A drop coinciding with a frame start is still reported.
    assign overflow_d = (frame_start ? 1'b0 : overflow_q) | drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            flush_cnt_q  <= '0;
            dut_valid_q  <= 1'b0;
            dut_act_q    <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            shreg_q      <= '0;
            beat_q       <= '0;
            ser_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            dut_valid_q  <= dut_valid_d;
            dut_act_q    <= dut_act_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            shreg_q      <= shreg_d;
            beat_q       <= beat_d;
            ser_vld_q    <= ser_vld_d;
        end
    end

    assign dut_valid  = dut_valid_q;
    assign dut_act    = dut_act_q;
    assign m_valid    = ser_vld_q;
    assign m_data     = shreg_q[SER_W-1:0];
    assign m_last     = ser_vld_q && (beat_q == LAST_BEAT);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule
